// File: rtl/drop_verdict_arbiter_pkg.sv
// Shared filter package: checker verdict type, arbiter state encoding and
// timeout defaults used by drop_verdict_arbiter and its timeout counter.
package drop_verdict_arbiter_pkg;

    // One checker verdict: tvalid = verdict present, tuser = drop request
    typedef struct packed {
        logic tvalid;
        logic tuser;
    } drop_source_t;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2
    } arb_state_t;

    // Default collection timeout in clk cycles (legal range 2..255)
    localparam int TIMEOUT_CYCLES_DEFAULT = 64;

    // Counter width large enough for the largest legal timeout
    localparam int TIMEOUT_CNT_W = 8;

endpackage

// File: rtl/drop_verdict_arbiter_if.sv
// Handshake bundle between the packet front end / checkers and the verdict
// arbiter. The master side issues packets, checker verdicts and downstream
// ready; the slave side (the arbiter) returns the combined verdict.
interface drop_verdict_arbiter_if #(
    parameter int NUM_CHECKERS = 4
) ();
    import drop_verdict_arbiter_pkg::*;

    logic                                pkt_start;
    drop_source_t [NUM_CHECKERS-1:0]     chk_drop;
    drop_source_t                        verdict;
    logic                                verdict_ready;

    modport master (
        output pkt_start,
        output chk_drop,
        output verdict_ready,
        input  verdict
    );

    modport slave (
        input  pkt_start,
        input  chk_drop,
        input  verdict_ready,
        output verdict
    );

endinterface

// File: rtl/drop_timeout_counter.sv
// Collection timeout counter for drop_verdict_arbiter.
// Only compiled when DROP_TIMEOUT_EN is defined; without it the arbiter has
// no timeout logic at all and this module does not exist.
// expired is high in the enabled cycle whose increment reaches LIMIT, so the
// arbiter leaves COLLECT at the end of the LIMIT-th collection cycle.
`ifdef DROP_TIMEOUT_EN
module drop_timeout_counter
    import drop_verdict_arbiter_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_CYCLES_DEFAULT,
    parameter int CNT_W = TIMEOUT_CNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    logic [CNT_W-1:0] count_r;

    // Cycle counter: clear has priority over counting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable && (count_r == CNT_W'(LIMIT - 1));

endmodule
`endif

// File: rtl/drop_verdict_arbiter.sv
// drop_verdict_arbiter: collects one drop verdict from each of NUM_CHECKERS
// checkers per packet, ORs the drop requests and presents a single combined
// verdict with a valid/ready handshake.
// Optional feature macro: DROP_TIMEOUT_EN -- when defined, a packet whose
// checkers do not all answer within TIMEOUT_CYCLES collection cycles is
// forced to a drop verdict and err_sticky[1] is set.
module drop_verdict_arbiter
    import drop_verdict_arbiter_pkg::*;
#(
    parameter int NUM_CHECKERS   = 4,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    drop_verdict_arbiter_if.slave  bus,
    output logic                   busy,
    output logic [1:0]             err_sticky
);

    if ((NUM_CHECKERS < 1) || (NUM_CHECKERS > 8) ||
        (TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255)) begin : g_param_range_bad
        $error("drop_verdict_arbiter: NUM_CHECKERS or TIMEOUT_CYCLES out of range");
    end

    arb_state_t              state_r;
    arb_state_t              state_nxt_s;
    logic [NUM_CHECKERS-1:0] done_r;
    logic [NUM_CHECKERS-1:0] done_nxt_s;
    logic [NUM_CHECKERS-1:0] chk_valid_s;
    logic [NUM_CHECKERS-1:0] chk_req_s;
    logic [NUM_CHECKERS-1:0] chk_new_s;
    logic                    drop_acc_r;
    logic                    drop_acc_nxt_s;
    logic                    verdict_valid_r;
    logic                    verdict_valid_nxt_s;
    logic                    verdict_drop_r;
    logic                    verdict_drop_nxt_s;
    logic                    busy_r;
    logic                    busy_nxt_s;
    logic                    err_proto_r;
    logic                    err_proto_set_s;
    logic                    err_timeout_s;
    logic                    handshake_s;
    logic                    start_accept_s;
    logic                    all_done_s;
    logic                    timeout_s;

    // Unpack per-checker strobes; a drop request only counts with tvalid
    always_comb begin
        chk_valid_s = '0;
        chk_req_s   = '0;
        for (int i = 0; i < NUM_CHECKERS; i++) begin
            chk_valid_s[i] = bus.chk_drop[i].tvalid;
            chk_req_s[i]   = bus.chk_drop[i].tvalid & bus.chk_drop[i].tuser;
        end
    end

    assign all_done_s     = &done_r;
    assign handshake_s    = (state_r == ST_EMIT) && bus.verdict_ready;
    // A packet is taken in IDLE, or in EMIT on the handshake cycle itself
    assign start_accept_s = bus.pkt_start && ((state_r == ST_IDLE) || handshake_s);
    assign chk_new_s      = chk_valid_s & ~done_r;

`ifdef DROP_TIMEOUT_EN
    logic expired_s;
    logic err_timeout_r;
    logic timeout_set_s;

    drop_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (TIMEOUT_CNT_W)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (state_r == ST_COLLECT),
        .clear   (start_accept_s),
        .expired (expired_s)
    );

    assign timeout_s     = expired_s;
    assign timeout_set_s = (state_r == ST_COLLECT) && !all_done_s && timeout_s;

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_timeout_r <= 1'b0;
        end else begin
            err_timeout_r <= err_timeout_r | timeout_set_s;
        end
    end

    assign err_timeout_s = err_timeout_r;
`else
    assign timeout_s     = 1'b0;
    assign err_timeout_s = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.pkt_start) begin
                    state_nxt_s = ST_COLLECT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (all_done_s || timeout_s) begin
                    state_nxt_s = ST_EMIT;
                end else begin
                    state_nxt_s = ST_COLLECT;
                end
            end
            ST_EMIT: begin
                if (handshake_s && bus.pkt_start) begin
                    state_nxt_s = ST_COLLECT;
                end else if (handshake_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Collection datapath: done mask, drop accumulator, protocol errors
    always_comb begin
        done_nxt_s      = done_r;
        drop_acc_nxt_s  = drop_acc_r;
        err_proto_set_s = 1'b0;
        case (state_r)
            ST_COLLECT: begin
                // Repeats from an already-done checker are discarded
                done_nxt_s      = done_r | chk_valid_s;
                drop_acc_nxt_s  = drop_acc_r | (|(chk_req_s & chk_new_s));
                err_proto_set_s = bus.pkt_start | (|(chk_valid_s & done_r));
            end
            ST_IDLE, ST_EMIT: begin
                if (start_accept_s) begin
                    // Verdicts arriving with pkt_start belong to the new packet
                    done_nxt_s     = chk_valid_s;
                    drop_acc_nxt_s = |chk_req_s;
                end else begin
                    err_proto_set_s = bus.pkt_start | (|chk_valid_s);
                end
            end
            default: begin
                done_nxt_s     = '0;
                drop_acc_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM output logic: next values of the registered outputs
    always_comb begin
        verdict_valid_nxt_s = (state_nxt_s == ST_EMIT);
        busy_nxt_s          = (state_nxt_s != ST_IDLE);
        if ((state_r == ST_COLLECT) && (state_nxt_s == ST_EMIT)) begin
            // Complete collection uses the accumulator; timeout forces drop
            if (all_done_s) begin
                verdict_drop_nxt_s = drop_acc_r;
            end else begin
                verdict_drop_nxt_s = 1'b1;
            end
        end else if (state_nxt_s == ST_EMIT) begin
            verdict_drop_nxt_s = verdict_drop_r;
        end else begin
            verdict_drop_nxt_s = 1'b0;
        end
    end

    // Collection datapath registers and sticky protocol error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_r      <= '0;
            drop_acc_r  <= 1'b0;
            err_proto_r <= 1'b0;
        end else begin
            done_r      <= done_nxt_s;
            drop_acc_r  <= drop_acc_nxt_s;
            err_proto_r <= err_proto_r | err_proto_set_s;
        end
    end

    // Registered verdict and busy outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            verdict_valid_r <= 1'b0;
            verdict_drop_r  <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            verdict_valid_r <= verdict_valid_nxt_s;
            verdict_drop_r  <= verdict_drop_nxt_s;
            busy_r          <= busy_nxt_s;
        end
    end

    assign bus.verdict = '{tvalid: verdict_valid_r, tuser: verdict_drop_r};
    assign busy        = busy_r;
    assign err_sticky  = {err_timeout_s, err_proto_r};

endmodule

// File: tb/tb_drop_verdict_arbiter.sv
// Directed self-checking bench for drop_verdict_arbiter (4 checkers,
// TIMEOUT_CYCLES = 8). Inputs change 1 time unit after the rising edge and
// outputs are sampled at the same point, i.e. they reflect that edge.
module tb_drop_verdict_arbiter;
    import drop_verdict_arbiter_pkg::*;

    localparam int NCHK = 4;
    localparam int TO   = 8;
`ifdef DROP_TIMEOUT_EN
    localparam int T7_ANS = 1000;   // checker 3 never answers
    localparam int T7_V   = TO;     // forced verdict after 8 collect cycles
`else
    localparam int T7_ANS = 20;     // checker 3 answers late
    localparam int T7_V   = 21;
`endif

    logic       clk;
    logic       reset_n;
    logic       busy;
    logic [1:0] err_sticky;
    logic       exp_v;
    int         n_compared   = 0;
    int         n_mismatched = 0;
    int         n_v;

    drop_verdict_arbiter_if #(.NUM_CHECKERS(NCHK)) bus ();

    drop_verdict_arbiter #(
        .NUM_CHECKERS   (NCHK),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .busy       (busy),
        .err_sticky (err_sticky)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic u,
                             input logic b, input logic [1:0] e);
        check_eq({tag, ".tvalid"}, 32'(bus.verdict.tvalid), 32'(v));
        check_eq({tag, ".tuser"},  32'(bus.verdict.tuser),  32'(u));
        check_eq({tag, ".busy"},   32'(busy),               32'(b));
        check_eq({tag, ".err"},    32'(err_sticky),         32'(e));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pkt_start     = 1'b0;
        bus.verdict_ready = 1'b0;
        for (int i = 0; i < NCHK; i++) begin
            bus.chk_drop[i] = 2'b00;
        end
    endtask

    task automatic set_chk(input int i, input logic v, input logic u);
        bus.chk_drop[i] = {v, u};
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #2;
        check_out(tag, 1'b0, 1'b0, 1'b0, 2'b00);
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1;
        idle_inputs();
        #1;
        do_reset("reset");

        // T1: all checkers answer with pkt_start, ready high
        bus.verdict_ready = 1'b1;
        bus.pkt_start     = 1'b1;
        for (int i = 0; i < NCHK; i++) set_chk(i, 1'b1, 1'b0);
        tick(); check_out("t1_e0", 1'b0, 1'b0, 1'b1, 2'b00);
        idle_inputs(); bus.verdict_ready = 1'b1;
        tick(); check_out("t1_e1", 1'b1, 1'b0, 1'b1, 2'b00);
        tick(); check_out("t1_e2", 1'b0, 1'b0, 1'b0, 2'b00);

        // T2: answers at 1,3,3,7, checker 2 drops, ready low 5 cycles
        for (int c = 0; c <= 15; c++) begin
            idle_inputs();
            bus.pkt_start = (c == 0);
            if (c == 1) set_chk(0, 1'b1, 1'b0);
            if (c == 3) begin
                set_chk(1, 1'b1, 1'b0);
                set_chk(2, 1'b1, 1'b1);
            end
            if (c == 7) set_chk(3, 1'b1, 1'b0);
            bus.verdict_ready = (c >= 14);
            tick();
            exp_v = (c >= 8) && (c <= 13);
            check_out($sformatf("t2_c%0d", c), exp_v, exp_v, (c <= 13), 2'b00);
        end

        // T3: duplicate verdict from checker 0 (its drop must be discarded)
        do_reset("t3_rst");
        n_v = 0;
        for (int c = 0; c <= 6; c++) begin
            idle_inputs();
            bus.verdict_ready = 1'b1;
            if (c == 0) begin
                bus.pkt_start = 1'b1;
                set_chk(0, 1'b1, 1'b0);
            end
            if (c == 1) set_chk(0, 1'b1, 1'b1);
            if (c == 2) for (int i = 1; i < NCHK; i++) set_chk(i, 1'b1, 1'b0);
            tick();
            if (bus.verdict.tvalid) begin
                n_v++;
                check_eq("t3_tuser", 32'(bus.verdict.tuser), 32'd0);
            end
            check_eq($sformatf("t3_err_c%0d", c), 32'(err_sticky), (c >= 1) ? 32'd1 : 32'd0);
        end
        check_eq("t3_vcount", 32'(n_v), 32'd1);

        // T4: handshake coincident with pkt_start, no idle bubble
        do_reset("t4_rst");
        bus.verdict_ready = 1'b1; bus.pkt_start = 1'b1;
        for (int i = 0; i < NCHK; i++) set_chk(i, 1'b1, 1'b0);
        tick(); check_out("t4_e0", 1'b0, 1'b0, 1'b1, 2'b00);
        idle_inputs(); bus.verdict_ready = 1'b1;
        tick(); check_out("t4_e1", 1'b1, 1'b0, 1'b1, 2'b00);
        bus.verdict_ready = 1'b1; bus.pkt_start = 1'b1;
        for (int i = 0; i < NCHK; i++) set_chk(i, 1'b1, (i == 1));
        tick(); check_out("t4_e2", 1'b0, 1'b0, 1'b1, 2'b00);
        idle_inputs(); bus.verdict_ready = 1'b1;
        tick(); check_out("t4_e3", 1'b1, 1'b1, 1'b1, 2'b00);
        tick(); check_out("t4_e4", 1'b0, 1'b0, 1'b0, 2'b00);

        // T5: pkt_start in EMIT without handshake is ignored and flagged
        do_reset("t5_rst");
        bus.pkt_start = 1'b1;
        for (int i = 0; i < NCHK; i++) set_chk(i, 1'b1, 1'b0);
        tick();
        idle_inputs();
        tick(); check_out("t5_e1", 1'b1, 1'b0, 1'b1, 2'b00);
        bus.pkt_start = 1'b1;
        tick(); check_out("t5_e2", 1'b1, 1'b0, 1'b1, 2'b01);
        idle_inputs(); bus.verdict_ready = 1'b1;
        tick(); check_out("t5_e3", 1'b0, 1'b0, 1'b0, 2'b01);
        idle_inputs();
        tick(); check_out("t5_e4", 1'b0, 1'b0, 1'b0, 2'b01);

        // T6: reset mid-COLLECT abandons the packet
        do_reset("t6_rst0");
        bus.pkt_start = 1'b1;
        set_chk(0, 1'b1, 1'b1);
        set_chk(1, 1'b1, 1'b1);
        tick(); check_out("t6_e0", 1'b0, 1'b0, 1'b1, 2'b00);
        idle_inputs();
        tick(); check_out("t6_e1", 1'b0, 1'b0, 1'b1, 2'b00);
        do_reset("t6_mid");
        for (int c = 0; c <= 4; c++) begin
            idle_inputs();
            bus.verdict_ready = 1'b1;
            if (c == 1) begin
                set_chk(2, 1'b1, 1'b0);
                set_chk(3, 1'b1, 1'b0);
            end
            tick();
            check_out($sformatf("t6_post_c%0d", c), 1'b0, 1'b0, 1'b0, (c >= 1) ? 2'b01 : 2'b00);
        end
        bus.verdict_ready = 1'b1; bus.pkt_start = 1'b1;
        for (int i = 0; i < NCHK; i++) set_chk(i, 1'b1, 1'b0);
        tick(); check_out("t6_new_e0", 1'b0, 1'b0, 1'b1, 2'b01);
        idle_inputs(); bus.verdict_ready = 1'b1;
        tick(); check_out("t6_new_e1", 1'b1, 1'b0, 1'b1, 2'b01);
        tick(); check_out("t6_new_e2", 1'b0, 1'b0, 1'b0, 2'b01);

        // T7: checker 3 silent -- timeout when enabled, else indefinite wait
        do_reset("t7_rst");
        for (int c = 0; c <= T7_V + 3; c++) begin
            idle_inputs();
            bus.verdict_ready = 1'b1;
            if (c == 0) begin
                bus.pkt_start = 1'b1;
                for (int i = 0; i < 3; i++) set_chk(i, 1'b1, 1'b0);
            end
            if (c == T7_ANS) set_chk(3, 1'b1, 1'b1);
            tick();
            exp_v = (c == T7_V);
`ifdef DROP_TIMEOUT_EN
            check_out($sformatf("t7_c%0d", c), exp_v, exp_v, (c <= T7_V), (c >= T7_V) ? 2'b10 : 2'b00);
`else
            check_out($sformatf("t7_c%0d", c), exp_v, exp_v, (c <= T7_V), 2'b00);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/drop_verdict_arbiter.md
DROP_VERDICT_ARBITER -- requirements
Module: drop_verdict_arbiter

Interface
REQ-001 SHALL have parameter NUM_CHECKERS, default 4, number of checker drop_source_t inputs (range 1..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, collection timeout in clk cycles (range 2..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port pkt_start  input  1  one-cycle pulse: header fields of a new packet were issued to all checkers.
REQ-006 SHALL have port chk_drop  input  drop_source_t[NUM_CHECKERS]  per-checker verdict; tvalid = verdict present, tuser = drop request.
REQ-007 SHALL have port verdict  output  drop_source_t  combined verdict; tvalid = valid, tuser = drop.
REQ-008 SHALL have port verdict_ready  input  1  downstream accepts verdict when verdict.tvalid && verdict_ready.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port err_sticky  output  2  bit0 protocol error, bit1 timeout; cleared only by reset.

Function
REQ-011 SHALL implement states IDLE, COLLECT, EMIT.
REQ-012 IDLE -> COLLECT on pkt_start; pending mask, drop accumulator and timeout counter SHALL be cleared in that cycle.
REQ-013 In COLLECT, each cycle chk_drop[i].tvalid SHALL set done[i] and OR chk_drop[i].tuser into the drop accumulator; multiple checkers in the same cycle are all accepted.
REQ-014 A checker verdict on the same cycle as pkt_start SHALL be counted toward the new packet.
REQ-015 COLLECT -> EMIT in the cycle after all NUM_CHECKERS done bits are set; verdict.tvalid SHALL rise on the next edge (minimum latency pkt_start to verdict.tvalid = 2 cycles when all checkers answer with pkt_start).
REQ-016 In EMIT, verdict.tvalid SHALL stay high and verdict.tuser stable until handshake; EMIT -> IDLE on handshake.
REQ-017 A handshake cycle with pkt_start high SHALL go directly to COLLECT (back-to-back packets, no idle bubble).
REQ-018 pkt_start in COLLECT or in EMIT without handshake SHALL be ignored and set err_sticky[0].
REQ-019 chk_drop[i].tvalid with done[i] already set, or in IDLE/EMIT, SHALL be discarded and set err_sticky[0].
REQ-020 Drop accumulator SHALL be a 1-bit OR; any checker drop yields verdict.tuser = 1.

Reset
REQ-021 On reset_n low, asynchronously: state IDLE, verdict.tvalid 0, verdict.tuser 0, busy 0, err_sticky 0, done mask 0, counter 0.
REQ-022 Reset mid-COLLECT or mid-EMIT SHALL abandon the packet; no verdict emitted after release until a new pkt_start.

Configuration
REQ-023 Macro DROP_TIMEOUT_EN SHALL gate the timeout feature.
REQ-024 With DROP_TIMEOUT_EN: counter increments each COLLECT cycle; on reaching TIMEOUT_CYCLES without all done bits, SHALL go to EMIT with verdict.tuser forced 1 and set err_sticky[1].
REQ-025 Without DROP_TIMEOUT_EN: no counter logic; COLLECT waits indefinitely; err_sticky[1] tied 0.

Structure
REQ-026 State enum and TIMEOUT_CYCLES default SHALL live in the shared filter package alongside drop_source_t.
REQ-027 Timeout counter SHALL be a sub-module drop_timeout_counter (enable, clear, expired), instantiated only with DROP_TIMEOUT_EN.

Verification
REQ-028 pkt_start with all 4 checkers tvalid=1, tuser=0 same cycle, verdict_ready=1 -> verdict.tvalid=1,tuser=0 two cycles later, one cycle wide.
REQ-029 Checkers answer at cycles 1,3,3,7, checker 2 tuser=1, verdict_ready=0 for 5 cycles -> verdict tuser=1 held stable until ready, then busy=0.
REQ-030 Duplicate tvalid from checker 0 in one packet -> err_sticky[0]=1, verdict still emitted once.
REQ-031 With DROP_TIMEOUT_EN, TIMEOUT_CYCLES=8, checker 3 silent -> verdict tuser=1 after 8 COLLECT cycles, err_sticky=2'b10.
REQ-032 Handshake coincident with pkt_start -> state COLLECT next cycle, no IDLE cycle, second verdict correct.
REQ-033 reset_n pulsed low mid-COLLECT -> all outputs 0 immediately; no verdict until next pkt_start.
